// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the mem_system port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rd;
    logic        wr;
  } mem_req_t;

  localparam int MAX_WAIT_DEF = 64;
  localparam int WAIT_W_DEF   = 7;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and mem_system signal bundle for mem_arbiter
interface mem_arbiter_if;
  logic [15:0] i_addr;
  logic        i_rd;
  logic [15:0] i_data_out;
  logic        i_done;
  logic        i_stall;

  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_data_out;
  logic        d_done;
  logic        d_stall;

  logic [15:0] m_addr;
  logic [15:0] m_data_in;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_data_out;
  logic        m_done;
  logic        m_err;

  logic        err;

  modport master (
    input  i_addr, i_rd, d_addr, d_data_in, d_rd, d_wr, m_data_out, m_done, m_err,
    output i_data_out, i_done, i_stall, d_data_out, d_done, d_stall,
    output m_addr, m_data_in, m_rd, m_wr, err
  );

  modport slave (
    output i_addr, i_rd, d_addr, d_data_in, d_rd, d_wr, m_data_out, m_done, m_err,
    input  i_data_out, i_done, i_stall, d_data_out, d_done, d_stall,
    input  m_addr, m_data_in, m_rd, m_wr, err
  );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational 2-way picker; MEM_ARB_DPRIO_EN selects strict data priority
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_DPRIO_EN
      grant_id = (last_grant == REQ_D) ? REQ_D : REQ_D;
`else
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
`endif
    end else if (d_req) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one mem_system port between fetch and data requesters, with watchdog
// Arbitration policy chosen in mem_arb_rr_pick (MEM_ARB_DPRIO_EN).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = WAIT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  req_id_t           last_grant_q, last_grant_d;
  req_id_t           owner_q, owner_d;
  mem_req_t          m_q, m_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [15:0]       i_data_q, i_data_d;
  logic [15:0]       d_data_q, d_data_d;
  logic              err_q, err_d;

  logic    i_req, d_req, grant_valid;
  req_id_t grant_id;

  assign i_req = bus.i_rd;
  assign d_req = bus.d_rd | bus.d_wr;

  mem_arb_rr_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;
      owner_q      <= REQ_I;
      m_q          <= '0;
      wait_q       <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_data_q     <= '0;
      d_data_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      m_q          <= m_d;
      wait_q       <= wait_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_data_q     <= i_data_d;
      d_data_q     <= d_data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    m_d          = '0;
    wait_d       = wait_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_data_d     = '0;
    d_data_d     = '0;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          wait_d       = '0;
          if (grant_id == REQ_D && bus.d_rd && bus.d_wr) begin
            // Conflicting load+store never reaches mem_system
            state_d  = FAULT;
            err_d    = 1'b1;
            d_done_d = 1'b1;
          end else if (grant_id == REQ_D) begin
            state_d = ISSUE;
            m_d     = '{addr: bus.d_addr, data: bus.d_data_in, rd: bus.d_rd, wr: bus.d_wr};
          end else begin
            state_d = ISSUE;
            m_d     = '{addr: bus.i_addr, data: 16'h0000, rd: 1'b1, wr: 1'b0};
          end
        end
      end

      ISSUE: begin
        m_d = m_q;
        if (bus.m_err || (!bus.m_done && wait_q == WAIT_LAST)) begin
          state_d  = FAULT;
          err_d    = 1'b1;
          m_d      = '0;
          i_done_d = (owner_q == REQ_I);
          d_done_d = (owner_q == REQ_D);
        end else if (bus.m_done) begin
          state_d  = RESP;
          m_d      = '0;
          i_done_d = (owner_q == REQ_I);
          d_done_d = (owner_q == REQ_D);
          if (owner_q == REQ_I) i_data_d = bus.m_data_out;
          else if (!m_q.wr)     d_data_d = bus.m_data_out;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_addr     = m_q.addr;
  assign bus.m_data_in  = m_q.data;
  assign bus.m_rd       = m_q.rd;
  assign bus.m_wr       = m_q.wr;
  assign bus.i_done     = i_done_q;
  assign bus.d_done     = d_done_q;
  assign bus.i_data_out = i_data_q;
  assign bus.d_data_out = d_data_q;
  assign bus.err        = err_q;
  assign bus.i_stall    = bus.i_rd & ~i_done_q;
  assign bus.d_stall    = (bus.d_rd | bus.d_wr) & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (honours MEM_ARB_DPRIO_EN)
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  logic [15:0] rdata = 16'h0000;
  logic        xor_mode = 1'b0;
  int          act_cnt = 0;
  int          hold_bad = 0;
  logic [15:0] exp_addr = 16'h0000;
  logic [15:0] exp_din = 16'h0000;

  // mem_system stand-in: Done after lat active cycles; lat=0 never completes
  always @(negedge clk) begin
    if (bus.m_rd || bus.m_wr) begin
      act_cnt = act_cnt + 1;
      if (bus.m_addr !== exp_addr || bus.m_data_in !== exp_din) hold_bad = hold_bad + 1;
    end else begin
      act_cnt = 0;
    end
    bus.m_done     = (bus.m_rd || bus.m_wr) && (act_cnt == lat);
    bus.m_err      = 1'b0;
    bus.m_data_out = xor_mode ? (bus.m_addr ^ 16'h5A5A) : rdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic single(input req_id_t side, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] din, input int l,
                        output int cyc, output logic [15:0] data, output int mcyc);
    logic done;
    lat = l;
    exp_addr = addr;
    exp_din = (side == REQ_I) ? 16'h0000 : din;
    hold_bad = 0;
    @(negedge clk);
    if (side == REQ_I) begin
      bus.i_addr = addr; bus.i_rd = 1'b1;
    end else begin
      bus.d_addr = addr; bus.d_data_in = din; bus.d_rd = rd; bus.d_wr = wr;
    end
    cyc = 0; mcyc = 0; data = 16'hxxxx; done = 1'b0;
    while (cyc < 200 && !done) begin
      @(negedge clk);
      cyc++;
      if (bus.m_rd || bus.m_wr) mcyc++;
      if (side == REQ_I && bus.i_done) begin data = bus.i_data_out; done = 1'b1; end
      if (side == REQ_D && bus.d_done) begin data = bus.d_data_out; done = 1'b1; end
    end
    bus.i_rd = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    chk("single_done_seen", done, 1'b1);
  endtask

  task automatic pair(output req_id_t first, output logic [15:0] idata,
                      output logic [15:0] ddata, output int stall_bad);
    logic idn, ddn;
    int cyc;
    lat = 1;
    @(negedge clk);
    bus.i_addr = 16'h0100; bus.i_rd = 1'b1;
    bus.d_addr = 16'h0200; bus.d_rd = 1'b1; bus.d_wr = 1'b0;
    idn = 1'b0; ddn = 1'b0; stall_bad = 0; cyc = 0; first = REQ_I;
    idata = 16'hxxxx; ddata = 16'hxxxx;
    while (cyc < 50 && !(idn && ddn)) begin
      @(negedge clk);
      cyc++;
      if (!idn) begin
        if (bus.i_done) begin
          idn = 1'b1; idata = bus.i_data_out; bus.i_rd = 1'b0;
          if (!ddn) first = REQ_I;
        end else if (!bus.i_stall) stall_bad++;
      end
      if (!ddn) begin
        if (bus.d_done) begin
          ddn = 1'b1; ddata = bus.d_data_out; bus.d_rd = 1'b0;
          if (!idn) first = REQ_D;
        end else if (!bus.d_stall) stall_bad++;
      end
    end
    chk("pair_both_done", {idn, ddn}, 2'b11);
  endtask

  int          cyc, mcyc, sb;
  logic [15:0] data, idata, ddata;
  req_id_t     first;
  req_id_t     exp_p12;

  initial begin
`ifdef MEM_ARB_DPRIO_EN
    exp_p12 = REQ_D;
`else
    exp_p12 = REQ_I;
`endif
    bus.i_addr = '0; bus.i_rd = 1'b0;
    bus.d_addr = '0; bus.d_data_in = '0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    bus.m_done = 1'b0; bus.m_err = 1'b0; bus.m_data_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_rd", bus.m_rd, 1'b0);
    chk("rst_m_addr", bus.m_addr, 16'h0000);
    chk("rst_i_done", bus.i_done, 1'b0);
    chk("rst_d_data_out", bus.d_data_out, 16'h0000);
    chk("rst_err", bus.err, 1'b0);
    rst = 1'b1;

    // hit on fetch
    rdata = 16'hBEEF;
    single(REQ_I, 1'b1, 1'b0, 16'h0010, 16'h0000, 1, cyc, data, mcyc);
    chk("t1_latency", cyc, 2);
    chk("t1_data", data, 16'hBEEF);
    chk("t1_m_rd_cycles", mcyc, 1);
    chk("t1_hold", hold_bad, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", bus.i_done, 1'b0);

    // store miss, 20 cycles in mem_system
    single(REQ_D, 1'b0, 1'b1, 16'h0408, 16'h1234, 20, cyc, data, mcyc);
    chk("t2_latency", cyc, 21);
    chk("t2_m_wr_cycles", mcyc, 20);
    chk("t2_hold", hold_bad, 0);
    chk("t2_data", data, 16'h0000);
    chk("t2_err", bus.err, 1'b0);

    // simultaneous requests, last_grant=D after the store
    xor_mode = 1'b1;
    pair(first, idata, ddata, sb);
    chk("t3_p1_first", first, exp_p12);
    chk("t3_p1_idata", idata, 16'h5B5A);
    chk("t3_p1_ddata", ddata, 16'h585A);
    chk("t3_p1_stall", sb, 0);
    pair(first, idata, ddata, sb);
    chk("t3_p2_first", first, exp_p12);
    chk("t3_p2_stall", sb, 0);
    single(REQ_I, 1'b1, 1'b0, 16'h0100, 16'h0000, 1, cyc, data, mcyc);
    pair(first, idata, ddata, sb);
    chk("t3_p3_first", first, REQ_D);
    xor_mode = 1'b0;

    // conflicting load+store
    rdata = 16'hBEEF;
    single(REQ_D, 1'b1, 1'b1, 16'h0300, 16'h7777, 1, cyc, data, mcyc);
    chk("t4_latency", cyc, 1);
    chk("t4_mem_untouched", mcyc, 0);
    chk("t4_data", data, 16'h0000);
    chk("t4_err", bus.err, 1'b1);
    single(REQ_I, 1'b1, 1'b0, 16'h0012, 16'h0000, 1, cyc, data, mcyc);
    chk("t4_normal_after_fault", data, 16'hBEEF);
    chk("t4_err_sticky", bus.err, 1'b1);

    // watchdog
    single(REQ_I, 1'b1, 1'b0, 16'h0020, 16'h0000, 0, cyc, data, mcyc);
    chk("t5_latency", cyc, 65);
    chk("t5_issue_cycles", mcyc, 64);
    chk("t5_data", data, 16'h0000);
    chk("t5_err", bus.err, 1'b1);

    // reset in the middle of ISSUE
    lat = 0;
    exp_addr = 16'h0030; exp_din = 16'h0000;
    @(negedge clk);
    bus.i_addr = 16'h0030; bus.i_rd = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_in_issue", bus.m_rd, 1'b1);
    #2;
    rst = 1'b0;
    bus.i_rd = 1'b0;
    #1;
    chk("t6_async_m_rd", bus.m_rd, 1'b0);
    chk("t6_async_m_addr", bus.m_addr, 16'h0000);
    chk("t6_async_err", bus.err, 1'b0);
    chk("t6_async_i_done", bus.i_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rdata = 16'hCAFE;
    single(REQ_I, 1'b1, 1'b0, 16'h0040, 16'h0000, 1, cyc, data, mcyc);
    chk("t6_post_latency", cyc, 2);
    chk("t6_post_data", data, 16'hCAFE);
    chk("t6_post_err", bus.err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
